// File: rtl/clock_pkg.sv
// Shared BCD time definitions for the alarm clock: field limits and positions,
// alarm FSM encoding and BCD helpers used by the timekeeper, display mux and entry stage.
package clock_pkg;

    localparam int TIME_W  = 24;
    localparam int FIELD_W = 8;

    localparam int HH_LSB = 16;
    localparam int MM_LSB = 8;
    localparam int SS_LSB = 0;

    localparam logic [FIELD_W-1:0] HOUR_MAX = 8'h23;
    localparam logic [FIELD_W-1:0] MIN_MAX  = 8'h59;
    localparam logic [FIELD_W-1:0] SEC_MAX  = 8'h59;

    typedef logic [TIME_W-1:0]  bcd_time_t;
    typedef logic [FIELD_W-1:0] bcd_field_t;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } alarm_state_t;

    function automatic bcd_field_t hh_field(input bcd_time_t t);
        return t[HH_LSB +: FIELD_W];
    endfunction

    function automatic bcd_field_t mm_field(input bcd_time_t t);
        return t[MM_LSB +: FIELD_W];
    endfunction

    function automatic bcd_field_t ss_field(input bcd_time_t t);
        return t[SS_LSB +: FIELD_W];
    endfunction

    // With both digits legal BCD, a plain binary compare orders fields like decimals.
    function automatic logic valid_field(input bcd_field_t f, input bcd_field_t max);
        return (f[3:0] <= 4'd9) && (f[7:4] <= 4'd9) && (f <= max);
    endfunction

    function automatic logic valid_time(input bcd_time_t t);
        return valid_field(hh_field(t), HOUR_MAX) &&
               valid_field(mm_field(t), MIN_MAX)  &&
               valid_field(ss_field(t), SEC_MAX);
    endfunction

    function automatic bcd_field_t field_next(input bcd_field_t f, input bcd_field_t max);
        bcd_field_t r;
        if (f == max)
            r = '0;
        else if (f[3:0] == 4'd9)
            r = {f[7:4] + 4'd1, 4'd0};
        else
            r = {f[7:4], f[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Running 24-hour BCD time register with parallel load and a one-second
// cascade increment (SS -> MM -> HH, wrapping 23:59:59 to 00:00:00).
module bcd_time_counter
    import clock_pkg::*;
(
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] load_value,
    input  logic              tick,
    output logic [TIME_W-1:0] ctime
);

    logic              ss_wrap;
    logic              mm_wrap;
    logic [TIME_W-1:0] ctime_inc;

    always_comb begin
        ss_wrap   = (ss_field(ctime) == SEC_MAX);
        mm_wrap   = (mm_field(ctime) == MIN_MAX);
        ctime_inc = ctime;
        ctime_inc[SS_LSB +: FIELD_W] = field_next(ss_field(ctime), SEC_MAX);
        if (ss_wrap)
            ctime_inc[MM_LSB +: FIELD_W] = field_next(mm_field(ctime), MIN_MAX);
        if (ss_wrap && mm_wrap)
            ctime_inc[HH_LSB +: FIELD_W] = field_next(hh_field(ctime), HOUR_MAX);
    end

    // A load in the same cycle as a tick takes priority and swallows the tick.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            ctime <= '0;
        else if (load)
            ctime <= load_value;
        else if (tick)
            ctime <= ctime_inc;
    end

endmodule

// File: rtl/alarm_time_keeper.sv
// Timekeeping and alarm core: synchronises the entry-stage strobes, validates loads,
// runs the one-second prescaler and the IDLE/RING alarm FSM. The load strobe is new_req
// because `new` is a reserved word.
module alarm_time_keeper
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int ALARM_LEN     = 60
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic [TIME_W-1:0] itime,
    input  logic              set,
    input  logic              new_req,
    input  logic              alarm_off,
    output logic [TIME_W-1:0] ctime,
    output logic [TIME_W-1:0] atime,
    output logic              alarm_en,
    output logic              alarm,
    output logic              sec_pulse,
    output logic              err
);

    localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RC_W = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(ALARM_LEN - 1);

    logic [2:0]        new_sync;
    logic [1:0]        set_sync;
    logic [2:0]        off_sync;
    logic              new_edge;
    logic              new_rise;
    logic              off_rise;
    logic [TIME_W-1:0] itime_hold;
    logic              set_hold;

    logic              load_ok;
    logic              clock_load;
    logic              alarm_load;

    logic [PS_W-1:0]   prescaler;
    logic              wrap;
    logic              tick;

    alarm_state_t      state;
    logic [RC_W-1:0]   ring_cnt;
    logic              ctime_match;

    assign new_edge = new_sync[1] & ~new_sync[2];

    // itime/set are captured while new is still guaranteed high, so a short strobe is safe.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            new_sync   <= '0;
            set_sync   <= '0;
            off_sync   <= '0;
            new_rise   <= 1'b0;
            off_rise   <= 1'b0;
            itime_hold <= '0;
            set_hold   <= 1'b0;
        end else begin
            new_sync <= {new_sync[1:0], new_req};
            set_sync <= {set_sync[0], set};
            off_sync <= {off_sync[1:0], alarm_off};
            new_rise <= new_edge;
            off_rise <= off_sync[1] & ~off_sync[2];
            if (new_edge) begin
                itime_hold <= itime;
                set_hold   <= set_sync[1];
            end
        end
    end

    assign load_ok     = valid_time(itime_hold);
    assign clock_load  = new_rise & load_ok & ~set_hold;
    assign alarm_load  = new_rise & load_ok & set_hold;
    assign wrap        = (prescaler == PS_LAST);
    assign tick        = wrap & ~clock_load;
    assign ctime_match = (ctime == atime);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            sec_pulse <= 1'b0;
            err       <= 1'b0;
            atime     <= '0;
            alarm_en  <= 1'b0;
        end else begin
            sec_pulse <= tick;
            err       <= new_rise & ~load_ok;
            if (clock_load || wrap)
                prescaler <= '0;
            else
                prescaler <= prescaler + PS_W'(1);
            if (alarm_load) begin
                atime    <= itime_hold;
                alarm_en <= 1'b1;
            end
        end
    end

    bcd_time_counter u_time_counter (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .load       (clock_load),
        .load_value (itime_hold),
        .tick       (tick),
        .ctime      (ctime)
    );

    // Matching is judged one cycle after the tick, against the freshly incremented ctime.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ring_cnt <= '0;
            alarm    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sec_pulse && alarm_en && ctime_match && !off_rise) begin
                        state    <= RING;
                        ring_cnt <= '0;
                        alarm    <= 1'b1;
                    end
                end
                RING: begin
                    if (off_rise || alarm_load || (sec_pulse && ring_cnt == RING_LAST)) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end else if (sec_pulse) begin
                        ring_cnt <= ring_cnt + RC_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/alarm_time_keeper.md
# alarm_time_keeper

Timekeeping and alarm core of the alarm clock. Consumes the 6-digit BCD HHMMSS word and the `set`/`new` strobes from the keyboard time-entry stage. Keeps a running 24-hour BCD time and a stored alarm time, and raises `alarm` when they match. Its outputs feed the seven-segment display mux and the buzzer driver.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: CLK100MHZ cycles per second.
- `ALARM_LEN`, default 60: seconds the alarm rings if it is not acknowledged.
- `CLK100MHZ` in 1: only clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `itime` in 24: BCD HH[23:16] MM[15:8] SS[7:0] from the entry stage. Stable while `new` is high.
- `set` in 1: target select, sampled at `new` rise. 0 = clock time, 1 = alarm time.
- `new` in 1: load request, asynchronous to CLK100MHZ, level held for ≥3 cycles.
- `alarm_off` in 1: push-button acknowledge, asynchronous, level.
- `ctime` out 24: current BCD time.
- `atime` out 24: stored BCD alarm time.
- `alarm_en` out 1: an alarm is armed.
- `alarm` out 1: alarm is ringing.
- `sec_pulse` out 1: one-cycle strobe on each second increment.
- `err` out 1: one-cycle strobe when a load is rejected.

## Operation
- Reset values: `ctime`=24'h000000, `atime`=24'h000000, `alarm_en`=0, `alarm`=0, `sec_pulse`=0, `err`=0, prescaler=0, FSM=IDLE.
- Synchronisers: `new`, `set`, `alarm_off` each pass through 2 flops. `new` and `alarm_off` are also rising-edge detected using a third flop.
- Load on a synced `new` rising edge:
  - Validate `itime`: every nibble ≤9, HH ≤ 23, MM ≤ 59, SS ≤ 59.
  - Invalid: no register changes; `err`=1 for one cycle.
  - Valid, synced `set`=0: `ctime`←`itime`, prescaler←0.
  - Valid, synced `set`=1: `atime`←`itime`, `alarm_en`←1. If FSM=RING, it returns to IDLE.
- Prescaler: counts 0..TICKS_PER_SEC-1 and wraps. At the wrap cycle `sec_pulse`=1 and `ctime` advances one second.
- BCD increment rules:
  - SS units 9→0 carries into SS tens; SS 59→00 carries into MM.
  - MM 59→00 carries into HH.
  - HH 09→10, 19→20, 23→00.
  - 23:59:59 → 00:00:00.
- Alarm FSM, 2 states:
  - IDLE → RING when a second increment makes the new `ctime` equal `atime` and `alarm_en`=1. Loading `ctime` equal to `atime` does not trigger.
  - RING → IDLE on a synced `alarm_off` edge, on a valid alarm load, or after ALARM_LEN `sec_pulse`s in RING. A ring-seconds counter is cleared on entry.
  - `alarm` = (state==RING). `alarm_en` stays 1 after ringing; the alarm re-arms daily.
- Simultaneous events:
  - Clock load and prescaler wrap in the same cycle: load wins, no increment, no `sec_pulse`.
  - `alarm_off` edge and match in the same cycle: stay IDLE.

## Timing
- `new` first sampled high at edge k: load is detected at edge k+2, and `ctime`/`atime`/`err` update at edge k+3.
- Wrap cycle at edge n (prescaler = TICKS_PER_SEC-1): `sec_pulse` is high and `ctime` updates at edge n+1. `alarm` rises at edge n+2.
- `alarm_off` edge sampled at edge k: `alarm` falls at edge k+3.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `reset` asserted mid-operation clears everything immediately. Loads in flight are lost.

## Structure
- Shared package `clock_pkg`:
  - BCD limit constants HOUR_MAX=8'h23, MIN_MAX=8'h59, SEC_MAX=8'h59.
  - Field slice localparams for HH/MM/SS.
  - FSM state encoding IDLE/RING.
  - Reused by the display mux and the entry stage.
- Sub-module `bcd_time_counter`: holds `ctime`. Inputs are load, load value, and tick. It performs the BCD cascade increment.
- Validation, synchronisers, prescaler and the FSM live in the top module.

## Test plan
All scenarios use TICKS_PER_SEC=4 and ALARM_LEN=3.
- Reset, then hold `new` for 5 cycles with `set`=0, `itime`=24'h235958. Required: `ctime`=235958 three edges after `new`; then `ctime`=235959, then 000000 on consecutive `sec_pulse`s.
- Load `ctime`=095959, then run 1 s. Required: `ctime`=100000. Load 195959, run 1 s. Required: 200000.
- Load `itime`=24'h246000 with `set`=0. Required: `err` pulses one cycle and `ctime` is unchanged. Repeat with 24'h12_5A_00. Required: `err` pulses again.
- Load alarm 24'h000005 (`set`=1) and clock 000003, then run. Required:
  - `alarm`=1 two edges after the `sec_pulse` that produced 000005.
  - `alarm` falls after 3 further `sec_pulse`s.
  - `alarm_en` stays 1.
- While ringing, raise `alarm_off`. Required: `alarm`=0 three edges later and `ctime` keeps counting.
- Load `ctime` equal to `atime` with `alarm_en`=1. Required: no ring. Then assert `reset` mid-ring. Required: all outputs return to reset values on the same edge.
